// File: rtl/xmodem_pkg.sv
// Shared definitions for the XMODEM receiver engine.
//   - protocol byte constants (SOH, STX, EOT, ACK, NAK, CAN, CRC_C)
//   - receiver state encoding xm_state_t
//   - blk_max(): buffer depth for a given 1K-block setting
//   - crc16_byte(): CRC-16-CCITT (poly 0x1021, MSB first) update by one byte
package xmodem_pkg;

  localparam logic [7:0] SOH   = 8'h01;
  localparam logic [7:0] STX   = 8'h02;
  localparam logic [7:0] EOT   = 8'h04;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;
  localparam logic [7:0] CAN   = 8'h18;
  localparam logic [7:0] CRC_C = 8'h43;

  typedef logic [3:0] xm_state_t;

  // Receive states are contiguous (S_HDR..S_CHK_LO) so the idle timer
  // can qualify on a simple range compare.
  localparam xm_state_t S_IDLE   = 4'd0;
  localparam xm_state_t S_INIT   = 4'd1;
  localparam xm_state_t S_HDR    = 4'd2;
  localparam xm_state_t S_SEQ    = 4'd3;
  localparam xm_state_t S_SEQN   = 4'd4;
  localparam xm_state_t S_DATA   = 4'd5;
  localparam xm_state_t S_CHK_HI = 4'd6;
  localparam xm_state_t S_CHK_LO = 4'd7;
  localparam xm_state_t S_DRAIN  = 4'd8;
  localparam xm_state_t S_ACK    = 4'd9;
  localparam xm_state_t S_NAK    = 4'd10;
  localparam xm_state_t S_CAN    = 4'd11;
  localparam xm_state_t S_DONE   = 4'd12;
  localparam xm_state_t S_ERR    = 4'd13;

  function automatic int blk_max(input bit allow_1k);
    return allow_1k ? 1024 : 128;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++)
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

endpackage

// File: rtl/xmodem_rx_gen_buf.sv
// xm_blk_buf: block payload buffer.
//   Simple dual-port RAM, DEPTH bytes. Byte-wide write port (waddr_i is a
//   byte address), OUT_BYTES-wide read port (raddr_i is a word address),
//   one-cycle registered read. Byte k of a word sits in rdata_o[8k+7:8k].
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o.
module xm_blk_buf #(
  parameter int DEPTH     = 1024,
  parameter int OUT_BYTES = 4
) (
  input  logic                                 clk_i,
  input  logic                                 we_i,
  input  logic [$clog2(DEPTH)-1:0]             waddr_i,
  input  logic [7:0]                           wdata_i,
  input  logic [$clog2(DEPTH/OUT_BYTES)-1:0]   raddr_i,
  output logic [8*OUT_BYTES-1:0]               rdata_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LB    = $clog2(OUT_BYTES);
  localparam int WORDS = DEPTH / OUT_BYTES;

  logic [OUT_BYTES-1:0][7:0] mem [WORDS];
  logic [AW-LB-1:0]          wword;

  assign wword = waddr_i[AW-1:LB];

  generate
    if (OUT_BYTES == 1) begin : g_b1
      always_ff @(posedge clk_i)
        if (we_i) mem[wword][0] <= wdata_i;
    end else begin : g_bn
      always_ff @(posedge clk_i)
        if (we_i) mem[wword][waddr_i[LB-1:0]] <= wdata_i;
    end
  endgenerate

  always_ff @(posedge clk_i)
    rdata_o <= mem[raddr_i];

endmodule

// File: rtl/xmodem_rx_gen.sv
// xmodem_rx_gen: XMODEM receiver engine (checksum or CRC-16, 128/1K blocks).
//   Buffers each block, verifies it, then drains it as OUT_BYTES-wide words
//   through a valid/ready port before acknowledging.
// Ports:
//   clk_i, rst_i (async, active high), start_i (session start pulse)
//   rx_byte_i/rx_valid_i  : byte stream from uart_rx
//   tx_byte_o/tx_valid_o/tx_ready_i : response byte to uart_tx
//   out_data_o/out_valid_o/out_ready_i : payload words, first byte in [7:0]
//   blk_done_o (pulse), block_cnt_o, xfer_done_o, xfer_err_o
module xmodem_rx_gen
  import xmodem_pkg::*;
#(
  parameter int USE_CRC     = 1,
  parameter int ALLOW_1K    = 1,
  parameter int OUT_BYTES   = 4,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int MAX_RETRY   = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [7:0]             rx_byte_i,
  input  logic                   rx_valid_i,
  output logic [7:0]             tx_byte_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [8*OUT_BYTES-1:0] out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   blk_done_o,
  output logic [15:0]            block_cnt_o,
  output logic                   xfer_done_o,
  output logic                   xfer_err_o
);
  localparam int BLK_MAX = blk_max(ALLOW_1K != 0);
  localparam int AW      = $clog2(BLK_MAX);
  localparam int LB      = $clog2(OUT_BYTES);
  localparam int WAW     = AW - LB;
  localparam int PW      = WAW + 1;
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam int RW      = $clog2(MAX_RETRY + 2) + 1;

  xm_state_t               state_q, state_d;
  logic [7:0]              seq_q, seq_d;
  logic [7:0]              hi_q, hi_d;
  logic [AW-1:0]           last_q, last_d;     // index of final data byte
  logic [AW-1:0]           idx_q, idx_d;
  logic [7:0]              sum_q, sum_d;
  logic [15:0]             crc_q, crc_d;
  logic [7:0]              exp_seq_q, exp_seq_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    got_hdr_q, got_hdr_d;
  logic                    eot_q, eot_d;
  logic [PW-1:0]           wptr_q, wptr_d;     // next word to fetch
  logic [WAW-1:0]          sent_q, sent_d;     // words handed off
  logic                    ld_q, ld_d;         // buffer read in flight
  logic                    ov_q, ov_d;
  logic [8*OUT_BYTES-1:0]  od_q, od_d;
  logic                    bd_q, bd_d;

  logic [8*OUT_BYTES-1:0]  rd_data;
  logic                    buf_we;
  logic                    counting, timeout, chk_ok, hs, issue;
  logic [WAW-1:0]          last_w;
  xm_state_t               fail_st;

  xm_blk_buf #(.DEPTH(BLK_MAX), .OUT_BYTES(OUT_BYTES)) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (idx_q),
    .wdata_i (rx_byte_i),
    .raddr_i (wptr_q[WAW-1:0]),
    .rdata_o (rd_data)
  );

  assign buf_we   = (state_q == S_DATA) && rx_valid_i;
  assign counting = (state_q >= S_HDR) && (state_q <= S_CHK_LO);
  assign timeout  = counting && !rx_valid_i && (timer_q == TW'(TIMEOUT_CYC - 1));
  assign chk_ok   = (USE_CRC != 0) ? ({hi_q, rx_byte_i} == crc_q) : (rx_byte_i == sum_q);
  assign last_w   = last_q[AW-1:LB];
  assign hs       = ov_q && out_ready_i;
  // A fetch is only launched when the output register is guaranteed free
  // by the time the read data lands, so no skid storage is needed.
  assign issue    = !ld_q && (!ov_q || hs) && (wptr_q <= {1'b0, last_w});
  // Once the retry budget is spent, the next failure cancels the session.
  assign fail_st  = (retry_q > RW'(MAX_RETRY)) ? S_CAN : S_NAK;

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    hi_d      = hi_q;
    last_d    = last_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    crc_d     = crc_q;
    exp_seq_d = exp_seq_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    got_hdr_d = got_hdr_q;
    eot_d     = eot_q;
    wptr_d    = wptr_q;
    sent_d    = sent_q;
    ld_d      = 1'b0;
    ov_d      = ov_q;
    od_d      = od_q;
    bd_d      = 1'b0;

    case (state_q)
      S_IDLE: if (start_i) state_d = S_INIT;
      S_INIT: if (tx_ready_i) state_d = S_HDR;
      S_HDR: if (rx_valid_i) begin
        case (rx_byte_i)
          SOH: begin
            last_d = AW'(127); got_hdr_d = 1'b1; state_d = S_SEQ;
          end
          STX: begin
            if (ALLOW_1K != 0) begin
              last_d = AW'(BLK_MAX - 1); got_hdr_d = 1'b1; state_d = S_SEQ;
            end else begin
              state_d = fail_st;
            end
          end
          EOT:     begin eot_d = 1'b1; state_d = S_ACK; end
          CAN:     state_d = S_ERR;
          default: ;
        endcase
      end
      S_SEQ: if (rx_valid_i) begin
        seq_d = rx_byte_i; state_d = S_SEQN;
      end
      S_SEQN: if (rx_valid_i) begin
        if (rx_byte_i != ~seq_q) begin
          state_d = fail_st;
        end else begin
          idx_d = '0; sum_d = '0; crc_d = '0; state_d = S_DATA;
        end
      end
      S_DATA: if (rx_valid_i) begin
        sum_d = sum_q + rx_byte_i;
        crc_d = crc16_byte(crc_q, rx_byte_i);
        idx_d = idx_q + AW'(1);
        if (idx_q == last_q) state_d = (USE_CRC != 0) ? S_CHK_HI : S_CHK_LO;
      end
      S_CHK_HI: if (rx_valid_i) begin
        hi_d = rx_byte_i; state_d = S_CHK_LO;
      end
      S_CHK_LO: if (rx_valid_i) begin
        if (!chk_ok)                         state_d = fail_st;
        else if (seq_q == exp_seq_q - 8'd1)  state_d = S_ACK;   // duplicate
        else if (seq_q == exp_seq_q) begin
          wptr_d = '0; sent_d = '0; state_d = S_DRAIN;
        end else                             state_d = S_CAN;
      end
      S_DRAIN: begin
        if (ld_q) begin
          od_d = rd_data; ov_d = 1'b1;
        end else if (hs) begin
          ov_d = 1'b0;
        end
        if (issue) begin
          ld_d = 1'b1; wptr_d = wptr_q + PW'(1);
        end
        if (hs) begin
          sent_d = sent_q + WAW'(1);
          if (sent_q == last_w) begin
            exp_seq_d = exp_seq_q + 8'd1;
            cnt_d     = cnt_q + 16'd1;
            retry_d   = '0;
            bd_d      = 1'b1;
            state_d   = S_ACK;
          end
        end
      end
      S_ACK: if (tx_ready_i) state_d = eot_q ? S_DONE : S_HDR;
      S_NAK: if (tx_ready_i) begin
        retry_d = retry_q + RW'(1); state_d = S_HDR;
      end
      S_CAN: if (tx_ready_i) state_d = S_ERR;
      default: ;
    endcase

    // Silence before any header means the sender has not noticed us yet.
    if (timeout) state_d = got_hdr_q ? fail_st : S_INIT;
  end

  assign timer_d = (counting && !rx_valid_i && (state_d == state_q)) ? timer_q + TW'(1) : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      seq_q     <= '0;
      hi_q      <= '0;
      last_q    <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      crc_q     <= '0;
      exp_seq_q <= 8'd1;
      cnt_q     <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      got_hdr_q <= 1'b0;
      eot_q     <= 1'b0;
      wptr_q    <= '0;
      sent_q    <= '0;
      ld_q      <= 1'b0;
      ov_q      <= 1'b0;
      od_q      <= '0;
      bd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      hi_q      <= hi_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      crc_q     <= crc_d;
      exp_seq_q <= exp_seq_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      got_hdr_q <= got_hdr_d;
      eot_q     <= eot_d;
      wptr_q    <= wptr_d;
      sent_q    <= sent_d;
      ld_q      <= ld_d;
      ov_q      <= ov_d;
      od_q      <= od_d;
      bd_q      <= bd_d;
    end
  end

  always_comb begin
    tx_valid_o = 1'b0;
    tx_byte_o  = 8'h00;
    case (state_q)
      S_INIT: begin tx_valid_o = 1'b1; tx_byte_o = (USE_CRC != 0) ? CRC_C : NAK; end
      S_ACK:  begin tx_valid_o = 1'b1; tx_byte_o = ACK; end
      S_NAK:  begin tx_valid_o = 1'b1; tx_byte_o = NAK; end
      S_CAN:  begin tx_valid_o = 1'b1; tx_byte_o = CAN; end
      default: ;
    endcase
  end

  assign out_data_o  = od_q;
  assign out_valid_o = ov_q;
  assign blk_done_o  = bd_q;
  assign block_cnt_o = cnt_q;
  assign xfer_done_o = (state_q == S_DONE);
  assign xfer_err_o  = (state_q == S_ERR);

endmodule

// File: tb/tb_xmodem_rx_gen.sv
// Testbench for xmodem_rx_gen: a CRC-mode instance (a) and a checksum-mode
// instance (b) share stimulus; sel picks which one is driven and observed.
// A transaction-level model predicts every tx byte and payload word.
module tb_xmodem_rx_gen;
  localparam int TO = 1000;
  localparam int MR = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       start = 1'b0, rx_valid = 1'b0, tx_ready = 1'b1, out_ready = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  bit         rand_rdy = 1'b0;

  logic [7:0]  tx_byte_a, tx_byte_b;
  logic        tx_valid_a, tx_valid_b, out_valid_a, out_valid_b;
  logic [31:0] out_data_a, out_data_b;
  logic        blk_done_a, blk_done_b, xfer_done_a, xfer_done_b, xfer_err_a, xfer_err_b;
  logic [15:0] block_cnt_a, block_cnt_b;

  xmodem_rx_gen #(.USE_CRC(1), .ALLOW_1K(1), .OUT_BYTES(4), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start && !sel), .rx_byte_i(rx_byte),
    .rx_valid_i(rx_valid && !sel), .tx_byte_o(tx_byte_a), .tx_valid_o(tx_valid_a),
    .tx_ready_i(tx_ready), .out_data_o(out_data_a), .out_valid_o(out_valid_a),
    .out_ready_i(out_ready), .blk_done_o(blk_done_a), .block_cnt_o(block_cnt_a),
    .xfer_done_o(xfer_done_a), .xfer_err_o(xfer_err_a));

  xmodem_rx_gen #(.USE_CRC(0), .ALLOW_1K(1), .OUT_BYTES(4), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start && sel), .rx_byte_i(rx_byte),
    .rx_valid_i(rx_valid && sel), .tx_byte_o(tx_byte_b), .tx_valid_o(tx_valid_b),
    .tx_ready_i(tx_ready), .out_data_o(out_data_b), .out_valid_o(out_valid_b),
    .out_ready_i(out_ready), .blk_done_o(blk_done_b), .block_cnt_o(block_cnt_b),
    .xfer_done_o(xfer_done_b), .xfer_err_o(xfer_err_b));

  wire [7:0]  m_tx_byte   = sel ? tx_byte_b   : tx_byte_a;
  wire        m_tx_valid  = sel ? tx_valid_b  : tx_valid_a;
  wire [31:0] m_out_data  = sel ? out_data_b  : out_data_a;
  wire        m_out_valid = sel ? out_valid_b : out_valid_a;
  wire        m_blk_done  = sel ? blk_done_b  : blk_done_a;
  wire [15:0] m_block_cnt = sel ? block_cnt_b : block_cnt_a;
  wire        m_xfer_done = sel ? xfer_done_b : xfer_done_a;
  wire        m_xfer_err  = sel ? xfer_err_b  : xfer_err_a;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, n_blk = 0;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_w[$];
  logic [31:0] got_w[$];
  int          tx_times[$];

  // model state
  logic [7:0] m_exp = 8'd1;
  int         m_cnt = 0;
  logic [7:0] blk [1024];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // compare process: every tx and payload handshake against the model queues
  always @(negedge clk) begin
    logic [7:0]  e8;
    logic [31:0] e32;
    if (!rst) begin
      if (m_tx_valid && tx_ready) begin
        tx_times.push_back(cyc);
        n_assert++;
        if (exp_tx.size() == 0) begin
          n_fail++;
          $display("FAIL tx_byte: got %02h, none expected (cycle %0d)", m_tx_byte, cyc);
        end else begin
          e8 = exp_tx.pop_front();
          if (m_tx_byte !== e8) begin
            n_fail++;
            $display("FAIL tx_byte: got %02h, expected %02h (cycle %0d)", m_tx_byte, e8, cyc);
          end
        end
      end
      if (m_out_valid && out_ready) begin
        got_w.push_back(m_out_data);
        n_assert++;
        if (exp_w.size() == 0) begin
          n_fail++;
          $display("FAIL out_data: got %08h, none expected (cycle %0d)", m_out_data, cyc);
        end else begin
          e32 = exp_w.pop_front();
          if (m_out_data !== e32) begin
            n_fail++;
            $display("FAIL out_data: got %08h, expected %08h (cycle %0d)", m_out_data, e32, cyc);
          end
        end
      end
      if (m_blk_done) n_blk++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c = 16'h0000;
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) begin
        logic fb = c[15] ^ blk[i][b];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  function automatic logic [7:0] sum_ref(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += blk[i];
    return 8'(s % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic wait_quiet(input string nm);
    int b = 0;
    while ((exp_tx.size() != 0 || exp_w.size() != 0) && b < 20000) begin
      @(posedge clk); b++;
    end
    chk({nm, "_pending"}, 32'(exp_tx.size() + exp_w.size()), 0);
    exp_tx.delete(); exp_w.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_start(output int st);
    @(posedge clk); #1;
    start = 1'b1; st = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_tx.delete(); exp_w.delete(); got_w.delete(); tx_times.delete();
    m_exp = 8'd1; m_cnt = 0; n_blk = 0;
  endtask

  // Builds a random block, predicts the receiver's reaction, then sends it.
  task automatic send_block(input logic [7:0] seq, input bit is1k, input bit corrupt, input bit crc_mode);
    int n = is1k ? 1024 : 128;
    logic [15:0] c;
    for (int i = 0; i < n; i++) blk[i] = 8'($urandom);
    c = crc_mode ? crc_ref(n) : {8'h00, sum_ref(n)};
    if (corrupt) c[7:0] = ~c[7:0];
    if (corrupt) exp_tx.push_back(8'h15);
    else if (seq == m_exp) begin
      for (int w = 0; w < n / 4; w++)
        exp_w.push_back({blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]});
      exp_tx.push_back(8'h06);
      m_exp = m_exp + 8'd1;
      m_cnt++;
    end else if (seq == m_exp - 8'd1) exp_tx.push_back(8'h06);
    else exp_tx.push_back(8'h18);
    send_byte(is1k ? 8'h02 : 8'h01);
    send_byte(seq);
    send_byte(~seq);
    for (int i = 0; i < n; i++) send_byte(blk[i]);
    if (crc_mode) send_byte(c[15:8]);
    send_byte(c[7:0]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [31:0] w0;

    // pin the reference model with known vectors ("123456789")
    for (int i = 0; i < 9; i++) blk[i] = 8'h31 + 8'(i);
    chk("model_crc16", 32'(crc_ref(9)), 32'h31C3);
    chk("model_sum", 32'(sum_ref(9)), 32'hDD);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_tx_valid", 32'(m_tx_valid), 0);
    chk("rst_out_valid", 32'(m_out_valid), 0);
    chk("rst_out_data", m_out_data, 0);
    chk("rst_block_cnt", 32'(m_block_cnt), 0);
    chk("rst_flags", {29'd0, m_blk_done, m_xfer_done, m_xfer_err}, 0);

    // ---- session A: CRC mode, initiator resend, good/bad/dup/out-of-order blocks
    sel = 1'b0;
    tx_times.delete();
    repeat (3) exp_tx.push_back(8'h43);
    do_start(st);
    wait_quiet("init_c");
    if (tx_times.size() >= 3) begin
      chk("init_latency_ok", 32'((tx_times[0] - st) <= 3), 1);
      chk("resend_gap1_ok", 32'((tx_times[1] - tx_times[0]) >= TO && (tx_times[1] - tx_times[0]) <= TO + 2), 1);
      chk("resend_gap2_ok", 32'((tx_times[2] - tx_times[1]) >= TO && (tx_times[2] - tx_times[1]) <= TO + 2), 1);
    end else chk("init_c_count", 32'(tx_times.size()), 3);

    got_w.delete();
    send_block(8'd1, 1'b0, 1'b0, 1'b1);
    w0 = {blk[3], blk[2], blk[1], blk[0]};
    wait_quiet("blk1");
    chk("blk1_words", 32'(got_w.size()), 32);
    if (got_w.size() > 0) chk("blk1_first_word", got_w[0], w0);
    chk("blk1_block_cnt", 32'(m_block_cnt), 1);
    chk("blk1_blk_done", 32'(n_blk), 1);

    send_block(8'd2, 1'b0, 1'b1, 1'b1);
    wait_quiet("blk2_bad");
    chk("blk2_bad_words", 32'(got_w.size()), 32);
    chk("blk2_bad_block_cnt", 32'(m_block_cnt), 1);

    send_block(8'd2, 1'b0, 1'b0, 1'b1);
    wait_quiet("blk2_good");
    chk("blk2_block_cnt", 32'(m_block_cnt), 32'(m_cnt));

    send_block(8'd2, 1'b0, 1'b0, 1'b1);
    wait_quiet("blk2_dup");
    chk("dup_words", 32'(got_w.size()), 64);
    chk("dup_block_cnt", 32'(m_block_cnt), 2);
    chk("dup_blk_done", 32'(n_blk), 2);

    send_block(8'd4, 1'b0, 1'b0, 1'b1);
    wait_quiet("blk_skip");
    chk("skip_xfer_err", 32'(m_xfer_err), 1);
    chk("skip_xfer_done", 32'(m_xfer_done), 0);

    // ---- session B: header then silence, repeatedly, until the session cancels
    do_reset();
    exp_tx.push_back(8'h43);
    do_start(st);
    wait_quiet("b_init");
    for (int k = 1; k <= 12; k++) begin
      exp_tx.push_back((k <= MR + 1) ? 8'h15 : 8'h18);
      send_byte(8'h01);
      wait_quiet("retry");
    end
    chk("retry_xfer_err", 32'(m_xfer_err), 1);
    chk("retry_block_cnt", 32'(m_block_cnt), 0);

    // ---- session C: reset in the middle of a block
    do_reset();
    exp_tx.push_back(8'h43);
    do_start(st);
    wait_quiet("c_init");
    send_block(8'd1, 1'b0, 1'b0, 1'b1);
    wait_quiet("c_blk1");
    chk("c_block_cnt_pre", 32'(m_block_cnt), 1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'hFD);
    for (int i = 0; i < 20; i++) send_byte(8'($urandom));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_block_cnt", 32'(m_block_cnt), 0);
    chk("midrst_tx_valid", 32'(m_tx_valid), 0);
    chk("midrst_out", {m_out_data[30:0], m_out_valid}, 0);
    do_reset();
    exp_tx.push_back(8'h43);
    do_start(st);
    wait_quiet("c_init2");
    send_block(8'd1, 1'b0, 1'b0, 1'b1);
    wait_quiet("c_blk1_again");
    chk("c_block_cnt_post", 32'(m_block_cnt), 1);

    // ---- session D: checksum mode, 128 then 1K block, stalling sink, EOT
    do_reset();
    sel = 1'b1;
    exp_tx.push_back(8'h15);
    do_start(st);
    wait_quiet("d_init");
    send_block(8'd1, 1'b0, 1'b0, 1'b0);
    wait_quiet("d_blk1");
    rand_rdy = 1'b1;
    send_block(8'd2, 1'b1, 1'b0, 1'b0);
    wait_quiet("d_blk2_1k");
    rand_rdy = 1'b0;
    chk("d_words", 32'(got_w.size()), 32 + 256);
    exp_tx.push_back(8'h06);
    send_byte(8'h04);
    wait_quiet("d_eot");
    chk("d_xfer_done", 32'(m_xfer_done), 1);
    chk("d_xfer_err", 32'(m_xfer_err), 0);
    chk("d_block_cnt", 32'(m_block_cnt), 2);
    chk("d_blk_done", 32'(n_blk), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/xmodem_rx_gen.md
Name: xmodem_rx_gen

Overview:
- Parametrised XMODEM receiver engine; next generation of the fixed 128-byte checksum loader.
- Sits between the board uart_rx byte stream / uart_tx and the scene-load writer that fills SDRAM/SRAM.
- Adds CRC-16 mode, 1K blocks (STX), duplicate-block handling, timeout/retry with abort, and a packed output word width.
- Payload is buffered per block and released only after the check passes.

Parameters:
- USE_CRC, 1: 1 = CRC-16-CCITT mode (initiator 'C'); 0 = 8-bit additive checksum (initiator NAK).
- ALLOW_1K, 1: 1 = accept STX 1024-byte blocks; 0 = STX is a bad header.
- OUT_BYTES, 4: bytes per out_data word (1, 2 or 4); 128 % OUT_BYTES == 0.
- TIMEOUT_CYC, 50_000_000: idle cycles before NAK/'C' resend.
- MAX_RETRY, 10: consecutive failures before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a session from IDLE, ignored elsewhere
- rx_byte  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- tx_byte  out  8  response byte
- tx_valid  out  1  held until tx_ready
- tx_ready  in  1  uart_tx accepts byte
- out_data  out  8*OUT_BYTES  packed payload, first byte in [7:0]
- out_valid  out  1  valid/ready source
- out_ready  in  1  sink ready
- blk_done  out  1  pulse per newly accepted block
- block_cnt  out  16  accepted non-duplicate blocks
- xfer_done  out  1  level, EOT acknowledged
- xfer_err  out  1  level, session aborted

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; exp_seq=1; retry=0; timer=0.
- States: IDLE, INIT, HDR, SEQ, SEQN, DATA, CHK_HI, CHK_LO, DRAIN, ACK, NAK, CAN, DONE, ERR.
- IDLE --start--> INIT: tx 'C' (0x43) or NAK (0x15) per USE_CRC, then HDR.
- HDR:
  - SOH (0x01) sets len=128.
  - STX (0x02) sets len=1024 if ALLOW_1K, else NAK.
  - EOT (0x04) goes to ACK then DONE.
  - CAN (0x18) goes to ERR, no tx.
  - Any other byte is dropped.
- SEQ/SEQN: capture seq, then seqn. seqn != ~seq goes to NAK.
- DATA: write byte to buffer at idx, idx 0..len-1. Running sum (mod 256) or CRC updates on each byte.
- CHK_HI/CHK_LO:
  - Checksum mode: one byte compared to sum; CHK_HI is skipped.
  - CRC mode: high byte first. CRC uses poly 0x1021, init 0x0000, MSB first.
- Verify (combinational on last check byte):
  - Mismatch goes to NAK.
  - seq == exp_seq-1 (mod 256) is a duplicate: ACK, no output, counters unchanged.
  - seq == exp_seq goes to DRAIN.
  - Any other seq goes to CAN: tx 0x18, then ERR.
- DRAIN:
  - Emits len/OUT_BYTES words; out_data/out_valid registered; word advances only on out_valid & out_ready.
  - After the last handshake: exp_seq++ (255 wraps to 0), block_cnt++, retry=0, go to ACK.
  - blk_done pulses in the cycle ACK first raises tx_valid.
- ACK/NAK/CAN: tx_valid=1 with fixed byte until tx_ready, then HDR (DONE or ERR where stated). NAK increments retry.
- Timeout:
  - timer clears on every rx_valid and state change; counts in HDR..CHK_LO.
  - Reaching TIMEOUT_CYC goes to NAK. Before the first valid header, it goes to INIT (resend initiator) instead.
- retry > MAX_RETRY goes to CAN then ERR.
- rx_valid during DRAIN/ACK/NAK/CAN/DONE/ERR is discarded.
- DONE and ERR hold until rst. rst mid-block drops all buffered data.
- start while not IDLE: ignored.

Decomposition:
- Package xmodem_pkg:
  - byte constants SOH, STX, EOT, ACK, NAK, CAN, CRC_C
  - state enum xm_state_t
  - function crc16_byte(crc, byte)
  - BLK_MAX = ALLOW_1K ? 1024 : 128
- Sub-module xm_blk_buf: simple dual-port RAM, 8-bit write port, OUT_BYTES-wide read port, 1-cycle read latency, BLK_MAX deep.
- DRAIN pipelines around that read latency.

Test Plan:
- CRC mode, start, idle bench → tx 0x43 within 1 cycle of INIT; resent every TIMEOUT_CYC (set 1000 in bench).
- SOH, 01, FE, 128 random bytes, correct CRC; OUT_BYTES=4 → 32 words, first word = {b3,b2,b1,b0}; tx 0x06; blk_done=1; block_cnt=1.
- Same block with CRC low byte inverted → tx 0x15; no out_valid; block_cnt stays 0. Resend without error → ACK, 32 words.
- Block 1 sent twice → second gets ACK, zero words, block_cnt=1. Block 3 after block 1 → tx 0x18, xfer_err=1.
- STX, seq 02, 1024 bytes, then EOT; USE_CRC=0 checksum → 256 words, ACK, then ACK to EOT, xfer_done=1. With out_ready toggled 50%, no word is lost or duplicated.
- Send 12 headers each followed by silence (MAX_RETRY=10) → 11 NAKs then CAN, xfer_err=1. rst asserted mid-DATA → all outputs 0 immediately.
